// File: rtl/trace_pkg.sv
// Shared types and constants for the core trace capture block.
package trace_pkg;

  // Capture controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DUMP  = 2'd3
  } trace_state_e;

  // Trigger source select codes
  localparam logic [1:0] TRIG_NOW  = 2'd0;
  localparam logic [1:0] TRIG_PC   = 2'd1;
  localparam logic [1:0] TRIG_MEMW = 2'd2;
  localparam logic [1:0] TRIG_EXT  = 2'd3;

  // Width of one trace entry {state, PC, Instr}
  function automatic int unsigned ENTRY_W(input int unsigned state_w, input int unsigned data_w);
    return state_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 68
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [WIDTH-1:0]           o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write one entry per sample
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of {state, PC, Instr} with trigger, post-trigger window
// and oldest-first valid/ready readout.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STATE_W = 4,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        arm,
  input  logic                        mode,
  input  logic [1:0]                  trig_sel,
  input  logic [DATA_W-1:0]           trig_val,
  input  logic                        trig_in,
  input  logic [CNT_W-1:0]            post_cnt,
  input  logic [DATA_W-1:0]           PC,
  input  logic [DATA_W-1:0]           Instr,
  input  logic [STATE_W-1:0]          state,
  input  logic                        IRWrite,
  input  logic                        MemWrite,
  input  logic [DATA_W-1:0]           Adr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [STATE_W+2*DATA_W-1:0] out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        triggered,
  output logic [CNT_W-1:0]            count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned EW  = ENTRY_W(STATE_W, DATA_W);

  trace_state_e      r_fsm;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_cnt_left;
  logic              r_triggered;
  logic              r_mode_q;
  logic [1:0]        r_sel_q;
  logic [DATA_W-1:0] r_val_q;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;

  logic              w_capturing;
  logic              w_sample;
  logic              w_trig_hit;
  logic              w_enter_dump;
  logic              w_arm_ok;
  logic [AW-1:0]     w_wr_ptr_inc;
  logic [CNT_W-1:0]  w_count_inc;
  logic [CNT_W-1:0]  w_post_clamp;
  logic [EW-1:0]     w_rd_data;

  // Sample only while capturing; an arm cycle never samples
  assign w_arm_ok     = arm && (r_fsm != ST_DUMP);
  assign w_capturing  = (r_fsm == ST_ARMED) || (r_fsm == ST_POST);
  assign w_sample     = w_capturing && (r_mode_q ? IRWrite : 1'b1) && !arm;
  assign w_wr_ptr_inc = r_wr_ptr + AW'(1);
  assign w_count_inc  = (r_count == CNT_W'(DEPTH)) ? r_count : r_count + CNT_W'(1);
  // Clamp keeps the trigger sample from being overwritten by the post window
  assign w_post_clamp = (post_cnt > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_cnt;
  assign w_enter_dump = w_sample &&
                        (((r_fsm == ST_ARMED) && w_trig_hit && (r_remaining == '0)) ||
                         ((r_fsm == ST_POST) && (r_remaining == CNT_W'(1))));

  // Trigger match against the live core signals
  always_comb begin
    w_trig_hit = 1'b0;
    case (r_sel_q)
      TRIG_NOW:  w_trig_hit = 1'b1;
      TRIG_PC:   w_trig_hit = (PC == r_val_q);
      TRIG_MEMW: w_trig_hit = MemWrite && (Adr == r_val_q);
      TRIG_EXT:  w_trig_hit = trig_in;
      default:   w_trig_hit = 1'b0;
    endcase
  end

  // Capture controller, pointers and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm       <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_cnt_left  <= '0;
      r_triggered <= 1'b0;
      r_mode_q    <= 1'b0;
      r_sel_q     <= '0;
      r_val_q     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_arm_ok) begin
      r_fsm       <= ST_ARMED;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_triggered <= 1'b0;
      r_mode_q    <= mode;
      r_sel_q     <= trig_sel;
      r_val_q     <= trig_val;
      r_remaining <= w_post_clamp;
      r_busy      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_sample) begin
        r_wr_ptr <= w_wr_ptr_inc;
        r_count  <= w_count_inc;
      end
      case (r_fsm)
        ST_ARMED: begin
          if (w_sample && w_trig_hit) begin
            r_triggered <= 1'b1;
            if (r_remaining != '0) r_fsm <= ST_POST;
          end
        end
        ST_POST: begin
          if (w_sample) r_remaining <= r_remaining - CNT_W'(1);
        end
        ST_DUMP: begin
          if (out_ready) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_cnt_left <= r_cnt_left - CNT_W'(1);
            r_out_last <= (r_cnt_left == CNT_W'(2));
            if (r_cnt_left == CNT_W'(1)) begin
              r_fsm       <= ST_IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (w_enter_dump) begin
        r_fsm       <= ST_DUMP;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b1;
        r_out_last  <= (w_count_inc == CNT_W'(1));
        r_cnt_left  <= w_count_inc;
        r_rd_ptr    <= (w_count_inc < CNT_W'(DEPTH)) ? '0 : w_wr_ptr_inc;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_sample),
    .i_waddr (r_wr_ptr),
    .i_wdata ({state, PC, Instr}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? w_rd_data : '0;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign triggered = r_triggered;
  assign count     = r_count;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed scoreboard bench for cpu_trace_buffer (DEPTH=8).
module tb_cpu_trace_buffer;
  import trace_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned EW      = STATE_W + 2 * DATA_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                arm;
  logic                mode;
  logic [1:0]          trig_sel;
  logic [DATA_W-1:0]   trig_val;
  logic                trig_in;
  logic [CNT_W-1:0]    post_cnt;
  logic [DATA_W-1:0]   PC;
  logic [DATA_W-1:0]   Instr;
  logic [STATE_W-1:0]  state;
  logic                IRWrite;
  logic                MemWrite;
  logic [DATA_W-1:0]   Adr;
  logic                out_valid;
  logic                out_ready;
  logic [EW-1:0]       out_data;
  logic                out_last;
  logic                busy;
  logic                triggered;
  logic [CNT_W-1:0]    count;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0]     model_q[$];
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] pc_m;

  always #5 clk = ~clk;

  cpu_trace_buffer #(
    .DATA_W (DATA_W), .STATE_W (STATE_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .reset (reset), .arm (arm), .mode (mode), .trig_sel (trig_sel),
    .trig_val (trig_val), .trig_in (trig_in), .post_cnt (post_cnt), .PC (PC),
    .Instr (Instr), .state (state), .IRWrite (IRWrite), .MemWrite (MemWrite),
    .Adr (Adr), .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_last (out_last), .busy (busy), .triggered (triggered), .count (count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic arm_cap(input logic m, input logic [1:0] sel, input logic [31:0] val,
                         input logic [CNT_W-1:0] post);
    mode = m; trig_sel = sel; trig_val = val; post_cnt = post;
    IRWrite = 1'b0; MemWrite = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    model_q.delete();
    pc_m = '0;
  endtask

  // Drive one core cycle; when it is a sample cycle, record it in the window model
  task automatic samp(input logic [3:0] st, input logic irw, input logic mw,
                      input logic [31:0] adr, input logic taken);
    state = st; IRWrite = irw; MemWrite = mw; Adr = adr;
    PC = pc_m; Instr = pc_m ^ 32'hE000_0000;
    if (taken) begin
      model_q.push_back({st, pc_m, pc_m ^ 32'hE000_0000});
      if (model_q.size() > int'(DEPTH)) void'(model_q.pop_front());
    end
    tick();
    if (taken) pc_m = pc_m + 32'd4;
    IRWrite = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic end_capture(input string tag, input int exp_count);
    check({tag, ".valid"}, 128'(out_valid), 128'(1));
    check({tag, ".busy"}, 128'(busy), 128'(0));
    check({tag, ".trig"}, 128'(triggered), 128'(1));
    check({tag, ".count"}, 128'(count), 128'(exp_count));
    exp_q = model_q;
  endtask

  // Drain the window; pat 0 = always ready, pat 1 = ready 1,0,0,1,0,0...
  task automatic dump_check(input string tag, input int pat);
    int cyc;
    int k;
    logic rdy;
    cyc = 0; k = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      check({tag, ".dvalid"}, 128'(out_valid), 128'(1));
      check({tag, ".data"}, 128'(out_data), 128'(exp_q[0]));
      check({tag, ".last"}, 128'(out_last), 128'(exp_q.size() == 1));
      rdy = (pat == 0) ? 1'b1 : ((k % 3) == 0);
      out_ready = rdy;
      k++;
      tick();
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, ".drained"}, 128'(exp_q.size()), 128'(0));
    check({tag, ".idle_valid"}, 128'(out_valid), 128'(0));
    check({tag, ".idle_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; mode = 1'b0; trig_sel = '0; trig_val = '0; trig_in = 1'b0;
    post_cnt = '0; PC = '0; Instr = '0; state = '0; IRWrite = 1'b0; MemWrite = 1'b0;
    Adr = '0; out_ready = 1'b0; pc_m = '0;
    tick(); tick();
    check("rst.valid", 128'(out_valid), 128'(0));
    check("rst.last", 128'(out_last), 128'(0));
    check("rst.busy", 128'(busy), 128'(0));
    check("rst.trig", 128'(triggered), 128'(0));
    check("rst.count", 128'(count), 128'(0));
    check("rst.data", 128'(out_data), 128'(0));
    reset = 1'b0;
    tick();

    // Immediate trigger, 3 post samples
    arm_cap(1'b0, TRIG_NOW, 32'h0, CNT_W'(3));
    check("imm.armed_busy", 128'(busy), 128'(1));
    check("imm.armed_count", 128'(count), 128'(0));
    for (int i = 0; i < 4; i++) samp(4'h5, 1'b0, 1'b0, 32'h0, 1'b1);
    end_capture("imm", 4);
    dump_check("imm", 0);
    check("imm.hold_count", 128'(count), 128'(4));
    check("imm.hold_trig", 128'(triggered), 128'(1));

    // PC trigger on the 9th sample, buffer wraps
    arm_cap(1'b0, TRIG_PC, 32'h20, CNT_W'(2));
    for (int i = 0; i < 8; i++) samp(4'(i), 1'b0, 1'b0, 32'h0, 1'b1);
    check("pc.pre_trig", 128'(triggered), 128'(0));
    check("pc.pre_count", 128'(count), 128'(8));
    for (int i = 8; i < 11; i++) samp(4'(i), 1'b0, 1'b0, 32'h0, 1'b1);
    end_capture("pc", 8);
    dump_check("pc", 0);

    // Fetch-only sampling, MemWrite trigger; a non-fetch MemWrite hit must be ignored
    arm_cap(1'b1, TRIG_MEMW, 32'h100, CNT_W'(1));
    for (int c = 0; c < 13; c++)
      samp(4'(c % 4), (c % 4) == 0, (c == 5) || (c == 8), 32'h100, (c % 4) == 0);
    end_capture("fetch", 4);
    dump_check("fetch", 0);

    // Back-pressure, plus an arm pulse during readout that must be ignored
    arm_cap(1'b0, TRIG_NOW, 32'h0, CNT_W'(3));
    for (int i = 0; i < 4; i++) samp(4'h9, 1'b0, 1'b0, 32'h0, 1'b1);
    end_capture("bp", 4);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("bp.arm_ignored_valid", 128'(out_valid), 128'(1));
    check("bp.arm_ignored_count", 128'(count), 128'(4));
    dump_check("bp", 1);

    // Post count clamped to DEPTH-1
    arm_cap(1'b0, TRIG_NOW, 32'h0, CNT_W'(20));
    for (int i = 0; i < 7; i++) samp(4'h3, 1'b0, 1'b0, 32'h0, 1'b1);
    check("clamp.still_busy", 128'(busy), 128'(1));
    check("clamp.no_dump", 128'(out_valid), 128'(0));
    samp(4'h3, 1'b0, 1'b0, 32'h0, 1'b1);
    end_capture("clamp", 8);
    check("clamp.first_pc", 128'(out_data[63:32]), 128'(0));
    dump_check("clamp", 0);

    // Re-arm while ARMED, then reset mid-POST
    arm_cap(1'b0, TRIG_PC, 32'hFFFF_FFF0, CNT_W'(0));
    for (int i = 0; i < 3; i++) samp(4'h2, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rearm.pre_count", 128'(count), 128'(3));
    arm_cap(1'b0, TRIG_NOW, 32'h0, CNT_W'(5));
    check("rearm.count", 128'(count), 128'(0));
    check("rearm.trig", 128'(triggered), 128'(0));
    check("rearm.busy", 128'(busy), 128'(1));
    for (int i = 0; i < 3; i++) samp(4'h2, 1'b0, 1'b0, 32'h0, 1'b1);
    check("post.trig", 128'(triggered), 128'(1));
    check("post.count", 128'(count), 128'(3));
    #2 reset = 1'b1;
    #1;
    check("midrst.busy", 128'(busy), 128'(0));
    check("midrst.trig", 128'(triggered), 128'(0));
    check("midrst.count", 128'(count), 128'(0));
    check("midrst.valid", 128'(out_valid), 128'(0));
    check("midrst.last", 128'(out_last), 128'(0));
    tick();
    reset = 1'b0;
    tick();
    arm_cap(1'b0, TRIG_NOW, 32'h0, CNT_W'(2));
    for (int i = 0; i < 3; i++) samp(4'h7, 1'b0, 1'b0, 32'h0, 1'b1);
    end_capture("after_rst", 3);
    dump_check("after_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
